// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// load/store path. Data has priority; a streak counter bounds how many data
// grants may pass a waiting fetch. A flush drops the in-flight fetch response.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,

  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,

  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_e      state_q, state_d;
  logic [3:0]  d_streak_q, d_streak_d;
  logic        drop_q, drop_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_rmask_q, mem_rmask_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic i_req, d_req, streak_full, grant_i, grant_d;

  // Arbitration: data wins unless fetch has already waited out a full streak.
  always_comb begin
    i_req       = (imem_rmask != '0);
    d_req       = ((dmem_rmask | dmem_wmask) != '0);
    streak_full = (d_streak_q == STREAK_MAX);
    grant_d     = (state_q == IDLE) && d_req && !(i_req && streak_full);
    grant_i     = (state_q == IDLE) && i_req && !grant_d;
  end

  // Next-state, memory-port and streak/drop bookkeeping.
  always_comb begin
    state_d     = state_q;
    d_streak_d  = d_streak_q;
    drop_d      = drop_q;
    mem_addr_d  = mem_addr_q;
    mem_rmask_d = mem_rmask_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          mem_addr_d  = dmem_addr;
          mem_rmask_d = dmem_rmask;
          mem_wmask_d = dmem_wmask;
          mem_wdata_d = dmem_wdata;
          if (i_req) begin
            d_streak_d = streak_full ? STREAK_MAX : d_streak_q + 4'd1;
          end else begin
            d_streak_d = '0;
          end
        end else if (grant_i) begin
          state_d     = I_BUSY;
          mem_addr_d  = imem_addr;
          mem_rmask_d = imem_rmask;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
          d_streak_d  = '0;
        end
      end
      I_BUSY: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_rmask_d = '0;
          mem_wmask_d = '0;
          drop_d      = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      D_BUSY: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_rmask_d = '0;
          mem_wmask_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      d_streak_q  <= '0;
      drop_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      d_streak_q  <= d_streak_d;
      drop_q      <= drop_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Responses are combinational from mem_resp; a flush coinciding with the
  // fetch response suppresses it just like a flush seen earlier.
  always_comb begin
    dmem_resp  = (state_q == D_BUSY) && mem_resp;
    imem_resp  = (state_q == I_BUSY) && mem_resp && !drop_q && !flush;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    mem_addr   = mem_addr_q;
    mem_rmask  = mem_rmask_q;
    mem_wmask  = mem_wmask_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule
